// File: rtl/lvlseq_pkg.sv
// Shared definitions for the level sequencer: FSM state encoding and default
// goal/score/timer constants.
package lvlseq_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } lvlseq_state_e;

    localparam int DEF_GOAL_X     = 482;
    localparam int DEF_GOAL_Y     = 108;
    localparam int DEF_SCORE_STEP = 1000;
    localparam int TIME_W         = 16;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter stepped by frame ticks; holds at zero and flags it.
module frame_down_counter #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    // Load wins over a tick arriving in the same clock.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/level_sequencer.sv
// Level controller: detects goal + score, runs the clear hold, advances levels.
// Optional per-level frame budget is enabled by defining LVLSEQ_TIME_LIMIT_EN.
module level_sequencer
    import lvlseq_pkg::*;
#(
    parameter int NUM_HEROES   = 2,
    parameter int POS_W        = 12,
    parameter int SCORE_W      = 24,
    parameter int LEVEL_W      = 4,
    parameter int MAX_LEVEL    = 10,
    parameter int GOAL_X       = DEF_GOAL_X,
    parameter int GOAL_Y       = DEF_GOAL_Y,
    parameter int SCORE_STEP   = DEF_SCORE_STEP,
    parameter int CLEAR_FRAMES = 60,
    parameter int TIME_FRAMES  = 3600
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic [SCORE_W-1:0]          score,
    input  logic [NUM_HEROES*POS_W-1:0] hero_x_pos,
    input  logic [NUM_HEROES*POS_W-1:0] hero_y_pos,
    output logic [LEVEL_W-1:0]          level,
    output logic [SCORE_W-1:0]          score_req,
    output logic                        hero_rst,
    output logic                        level_clear,
    output logic                        game_done
`ifdef LVLSEQ_TIME_LIMIT_EN
    ,
    output logic [TIME_W-1:0]           time_left,
    output logic                        timeout
`endif
);

    localparam int                 HOLD_W     = $clog2(CLEAR_FRAMES + 1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(CLEAR_FRAMES);

    lvlseq_state_e        state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [SCORE_W-1:0]   score_req_q, score_req_d;
    logic                 hero_rst_q, hero_rst_d;
    logic                 level_clear_q, level_clear_d;
    logic                 game_done_q, game_done_d;

    logic                 all_on_goal;
    logic                 goal_hit;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;

    logic                 hold_load, hold_tick, hold_zero;
    logic [HOLD_W-1:0]    hold_count_unused;

    // Goal detection and the saturating next-level score requirement.
    always_comb begin
        all_on_goal = 1'b1;
        for (int i = 0; i < NUM_HEROES; i++) begin
            if ((hero_x_pos[i*POS_W +: POS_W] != POS_W'(GOAL_X)) ||
                (hero_y_pos[i*POS_W +: POS_W] != POS_W'(GOAL_Y))) begin
                all_on_goal = 1'b0;
            end
        end
        goal_hit   = all_on_goal && (score >= score_req_q);
        score_sum  = {1'b0, score} + (SCORE_W+1)'(SCORE_STEP);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    // Loading on CLEAR entry means a tick in that same clock is not counted.
    assign hold_load = (state_q == ST_PLAY) && goal_hit;
    assign hold_tick = (state_q == ST_CLEAR) && frame_tick;

    frame_down_counter #(
        .WIDTH     (HOLD_W),
        .RESET_VAL ('0)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .tick     (hold_tick),
        .count    (hold_count_unused),
        .zero     (hold_zero)
    );

`ifdef LVLSEQ_TIME_LIMIT_EN
    logic              timer_load, timer_tick, timer_zero;
    logic [TIME_W-1:0] timer_count;
    logic              timeout_q, timeout_d;

    assign timer_tick = (state_q == ST_PLAY) && frame_tick && !goal_hit;

    frame_down_counter #(
        .WIDTH     (TIME_W),
        .RESET_VAL (TIME_W'(TIME_FRAMES))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIME_W'(TIME_FRAMES)),
        .tick     (timer_tick),
        .count    (timer_count),
        .zero     (timer_zero)
    );
`endif

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        score_req_d   = score_req_q;
        hero_rst_d    = 1'b0;
        level_clear_d = 1'b0;
        game_done_d   = game_done_q;
`ifdef LVLSEQ_TIME_LIMIT_EN
        timer_load    = 1'b0;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            ST_PLAY: begin
                if (goal_hit) begin
                    state_d       = ST_CLEAR;
                    level_clear_d = 1'b1;
                    score_req_d   = score_next;
                end
`ifdef LVLSEQ_TIME_LIMIT_EN
                else if (timer_zero) begin
                    timeout_d  = 1'b1;
                    hero_rst_d = 1'b1;
                    timer_load = 1'b1;
                end
`endif
            end
            ST_CLEAR: begin
                if (hold_zero) begin
                    if (level_q == LAST_LEVEL) begin
                        state_d     = ST_DONE;
                        game_done_d = 1'b1;
                    end else begin
                        state_d    = ST_PLAY;
                        level_d    = level_q + LEVEL_W'(1);
                        hero_rst_d = 1'b1;
`ifdef LVLSEQ_TIME_LIMIT_EN
                        timer_load = 1'b1;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_PLAY;
            level_q       <= '0;
            score_req_q   <= SCORE_W'(SCORE_STEP);
            hero_rst_q    <= 1'b0;
            level_clear_q <= 1'b0;
            game_done_q   <= 1'b0;
`ifdef LVLSEQ_TIME_LIMIT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            score_req_q   <= score_req_d;
            hero_rst_q    <= hero_rst_d;
            level_clear_q <= level_clear_d;
            game_done_q   <= game_done_d;
`ifdef LVLSEQ_TIME_LIMIT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign level       = level_q;
    assign score_req   = score_req_q;
    assign hero_rst    = hero_rst_q;
    assign level_clear = level_clear_q;
    assign game_done   = game_done_q;
`ifdef LVLSEQ_TIME_LIMIT_EN
    assign time_left   = timer_count;
    assign timeout     = timeout_q;
`endif

endmodule
